lsu: RTL

Load/store unit between the CPU memory-access stage and the word-wide `memory` block. It accepts byte, half-word and word requests on byte addresses. It performs loads with lane extraction and sign/zero extension. The memory supports only full-word writes, so sub-word stores are done as read-modify-write. Misaligned and illegal-size requests are rejected without touching memory.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_if.sv | 18 +
 rtl/lsu_align.sv | 37 +++
 rtl/lsu.sv | 90 +++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and types for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} lsu_state_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } lsu_req_t;

    // Misaligned halves/words and the reserved size are rejected
    function automatic logic lsu_is_err(input logic [1:0] size, input logic [1:0] lo);
        return (size == SIZE_X) || (size == SIZE_H && lo[0]) || (size == SIZE_W && lo != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU-side request/response bundle of the load/store unit.
interface lsu_if #(parameter int AW = 14);
    logic          req_i;
    logic          we_i;
    logic [1:0]    size_i;
    logic          unsigned_i;
    logic [AW-1:0] addr_i;
    logic [31:0]   wdata_i;
    logic          ready_o;
    logic          done_o;
    logic          err_o;
    logic [31:0]   rdata_o;

    modport master (output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
                    input  ready_o, done_o, err_o, rdata_o);
    modport slave  (input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
                    output ready_o, done_o, err_o, rdata_o);
endinterface

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, lane merge for stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] data,
    output logic [31:0] ld,
    output logic [31:0] st
);
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b  = word[{lo, 3'b000} +: 8];
        h  = word[{lo[1], 4'b0000} +: 16];
        ld = word;
        st = data;
        case (size)
            SIZE_B: begin
                ld = {{24{~uns & b[7]}}, b};
                st = word;
                st[{lo, 3'b000} +: 8] = data[7:0];
            end
            SIZE_H: begin
                ld = {{16{~uns & h[15]}}, h};
                st = word;
                st[{lo[1], 4'b0000} +: 16] = data[15:0];
            end
            default: begin
                ld = word;
                st = data;
            end
        endcase
    end
endmodule

// File: rtl/lsu.sv
// Load/store unit: byte/half/word access to a word-wide memory, sub-word stores via read-modify-write.
module lsu
    import lsu_pkg::*;
#(
    parameter  int NUMWORDS = 4096,
    localparam int AW       = $clog2(NUMWORDS) + 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    lsu_if.slave          cpu,
    output logic          mem_re_o,
    output logic [AW-3:0] mem_raddr_o,
    input  logic [31:0]   mem_rdata_i,
    output logic          mem_we_o,
    output logic [AW-3:0] mem_waddr_o,
    output logic [31:0]   mem_wdata_o
);
    lsu_state_t    state, nxt;
    lsu_req_t      rq;
    logic [AW-1:0] addr_q;
    logic          err_q;
    logic [31:0]   rdata_q, mbuf, ld, st;
    logic          acc, acc_err;

    assign acc     = (state == IDLE) && cpu.req_i;
    assign acc_err = lsu_is_err(cpu.size_i, cpu.addr_i[1:0]);

    lsu_align u_align (
        .word (mem_rdata_i),
        .lo   (addr_q[1:0]),
        .size (rq.size),
        .uns  (rq.uns),
        .data (rq.wdata),
        .ld   (ld),
        .st   (st)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (cpu.req_i) begin
                if (acc_err)                  nxt = RESP;
                else if (!cpu.we_i)           nxt = LOAD;
                else if (cpu.size_i == SIZE_W) nxt = WRITE;
                else                          nxt = RMW_RD;
            end
            LOAD:    nxt = RESP;
            RMW_RD:  nxt = WRITE;
            WRITE:   nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Enables are gated by reset so an abandoned request never reaches memory
    always_comb begin
        cpu.ready_o = (state == IDLE);
        cpu.done_o  = (state == RESP);
        cpu.err_o   = (state == RESP) && err_q;
        cpu.rdata_o = rdata_q;
        mem_re_o    = !rst_i && (state == LOAD || state == RMW_RD);
        mem_we_o    = !rst_i && (state == WRITE);
        mem_raddr_o = addr_q[AW-1:2];
        mem_waddr_o = addr_q[AW-1:2];
        mem_wdata_o = (rq.size == SIZE_W) ? rq.wdata : mbuf;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rq      <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            mbuf    <= '0;
        end else begin
            if (acc) begin
                rq     <= '{we: cpu.we_i, size: cpu.size_i, uns: cpu.unsigned_i, wdata: cpu.wdata_i};
                addr_q <= cpu.addr_i;
                err_q  <= acc_err;
            end
            if (state == LOAD)   rdata_q <= ld;
            if (state == RMW_RD) mbuf    <= st;
        end
    end
endmodule
